// File: rtl/aq_ifu_pre_decd_mw.sv
// aq_ifu_pre_decd_mw: registered multi-slot LoongArch branch pre-decoder feeding the ID-stage predictor
//   cpuclk/cpurst           clock, asynchronous active-high reset
//   ifu_pdec_flush          drop the held result and this cycle's input
//   ipack_pdec_*            fetch packet in: vld/rdy handshake, slot-0 pc, instructions, slot mask
//   id_pdec_rdy             ID consumes the held result
//   pdec_id_*               registered result: slot valids, classes, immediates, first change of flow
module aq_ifu_pre_decd_mw #(
  parameter int INST_NUM = 2,
  parameter int PC_WIDTH = 40,
  parameter int BTFN_EN  = 0,
  parameter int IDX_W    = (INST_NUM > 1) ? $clog2(INST_NUM) : 1
) (
  input  logic                     cpuclk,
  input  logic                     cpurst,
  input  logic                     ifu_pdec_flush,
  input  logic                     ipack_pdec_vld,
  output logic                     pdec_ipack_rdy,
  input  logic [PC_WIDTH-1:0]      ipack_pdec_pc,
  input  logic [32*INST_NUM-1:0]   ipack_pdec_inst,
  input  logic [INST_NUM-1:0]      ipack_pdec_inst_vld,
  input  logic                     id_pdec_rdy,
  output logic                     pdec_id_vld,
  output logic [INST_NUM-1:0]      pdec_id_inst_vld,
  output logic [INST_NUM-1:0]      pdec_id_br_vld,
  output logic [INST_NUM-1:0]      pdec_id_jmp_vld,
  output logic [INST_NUM-1:0]      pdec_id_link_vld,
  output logic [INST_NUM-1:0]      pdec_id_ret_vld,
  output logic [40*INST_NUM-1:0]   pdec_id_imm,
  output logic                     pdec_id_chgflw_vld,
  output logic [IDX_W-1:0]         pdec_id_chgflw_idx,
  output logic [PC_WIDTH-1:0]      pdec_id_chgflw_tar
);
  logic [INST_NUM-1:0]          br, jmp, link, ret, cand, keep;
  logic [40*INST_NUM-1:0]       imm;
  logic [PC_WIDTH*INST_NUM-1:0] tar;
  logic                         found;
  logic [IDX_W-1:0]             c_idx;
  logic [PC_WIDTH-1:0]          c_tar;
  genvar g;
  for (g = 0; g < INST_NUM; g++) begin : g_slot
    logic [31:0] w;
    logic [5:0]  op;
    logic        v, bz, bc, j;
    assign w  = ipack_pdec_inst[32*g +: 32];
    assign op = w[31:26];
    assign v  = ipack_pdec_inst_vld[g];
    // beqz/bnez, and bceqz/bcnez whose inst[9:8] is 00 or 01
    assign bz = op == 6'b010000 || op == 6'b010001 || (op == 6'b010010 && !w[9]);
    assign bc = op >= 6'b010110 && op <= 6'b011011;
    assign j  = op == 6'b010100 || op == 6'b010101;
    assign br[g]   = v && (bz || bc);
    assign jmp[g]  = v && j;
    assign link[g] = v && (op == 6'b010101 || (op == 6'b010011 && w[4:0] == 5'd1));
    assign ret[g]  = v && op == 6'b010011 && w[9:5] == 5'd1 && w[4:0] != 5'd1;
    assign imm[40*g +: 40] = !v ? '0 :
                             bz ? {{17{w[4]}}, w[4:0], w[25:10], 2'b00} :
                             bc ? {{22{w[25]}}, w[25:10], 2'b00} :
                             j  ? {{12{w[9]}}, w[9:0], w[25:10], 2'b00} : '0;
    assign cand[g] = jmp[g] || (BTFN_EN != 0 && br[g] && imm[40*g+39]);
    // slot pc plus offset, wrapping at PC_WIDTH
    assign tar[PC_WIDTH*g +: PC_WIDTH] = ipack_pdec_pc + PC_WIDTH'(4*g) + imm[40*g +: PC_WIDTH];
  end
  always_comb begin
    found = 1'b0;
    c_idx = '0;
    c_tar = '0;
    keep  = '0;
    for (int i = 0; i < INST_NUM; i++) begin
      keep[i] = ipack_pdec_inst_vld[i] && !found;
      c_idx   = (cand[i] && !found) ? IDX_W'(i) : c_idx;
      c_tar   = (cand[i] && !found) ? tar[PC_WIDTH*i +: PC_WIDTH] : c_tar;
      found   = found | cand[i];
    end
  end
  assign pdec_ipack_rdy = !ifu_pdec_flush && (!pdec_id_vld || id_pdec_rdy);
  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      pdec_id_vld        <= 1'b0;
      pdec_id_inst_vld   <= '0;
      pdec_id_br_vld     <= '0;
      pdec_id_jmp_vld    <= '0;
      pdec_id_link_vld   <= '0;
      pdec_id_ret_vld    <= '0;
      pdec_id_imm        <= '0;
      pdec_id_chgflw_vld <= 1'b0;
      pdec_id_chgflw_idx <= '0;
      pdec_id_chgflw_tar <= '0;
    end else if (ifu_pdec_flush) begin
      pdec_id_vld <= 1'b0;
    end else if (ipack_pdec_vld && pdec_ipack_rdy) begin
      pdec_id_vld        <= 1'b1;
      pdec_id_inst_vld   <= keep;
      pdec_id_br_vld     <= br & keep;
      pdec_id_jmp_vld    <= jmp & keep;
      pdec_id_link_vld   <= link & keep;
      pdec_id_ret_vld    <= ret & keep;
      pdec_id_imm        <= imm;
      pdec_id_chgflw_vld <= |cand;
      pdec_id_chgflw_idx <= c_idx;
      pdec_id_chgflw_tar <= c_tar;
    end else if (id_pdec_rdy) begin
      pdec_id_vld <= 1'b0;
    end
  end
endmodule
